// File: rtl/pix_pkg.sv
// ---------------------------------------------------------------------------
// pix_pkg
// Shared constants, types and helpers for the pix_adjust gain/offset pixel
// stage and its per-channel datapath.
//   LATENCY    : data_i -> data_o pipeline depth in clocks
//   sync_t     : bundle of the three video sync/enable signals
//   unity_gain : gain code that represents 1.0 for a given fractional width
//   ch_lo      : low bit index of channel k in a packed per-channel bus
// ---------------------------------------------------------------------------
package pix_pkg;

  localparam int LATENCY = 3;

  typedef struct packed {
    logic vde;
    logic hsync;
    logic vsync;
  } sync_t;

  function automatic int unsigned unity_gain(input int unsigned frac);
    return 32'd1 << frac;
  endfunction

  function automatic int unsigned ch_lo(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/pix_chan.sv
// ---------------------------------------------------------------------------
// pix_chan
// One colour channel of the pixel stage: fixed-point multiply, round, signed
// offset, clamp to [0, 2^DW-1]. Three register stages; the per-pixel gain,
// offset and bypass travel with the pixel so in-flight pixels keep the
// configuration they entered with.
// Ports:
//   clk, rst_n  : pixel clock, asynchronous active-low reset
//   i_pix       : channel sample entering stage 1
//   i_gain      : unsigned gain, FRAC fractional bits (active config)
//   i_ofs       : two's complement offset (active config)
//   i_bypass    : pass the sample through unmodified
//   i_vde_s3    : video enable aligned with the stage-3 register load
//   o_data      : processed sample (0 when vde low)
//   o_sat       : sample was clamped at either bound while vde high
// ---------------------------------------------------------------------------
module pix_chan
  import pix_pkg::*;
#(
  parameter int DW     = 8,
  parameter int GAIN_W = 9,
  parameter int FRAC   = 7,
  parameter int OFS_W  = DW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     i_pix,
  input  logic [GAIN_W-1:0] i_gain,
  input  logic [OFS_W-1:0]  i_ofs,
  input  logic              i_bypass,
  input  logic              i_vde_s3,
  output logic [DW-1:0]     o_data,
  output logic              o_sat
);

  localparam int PW = DW + GAIN_W;   // product width
  localparam int SW = PW + 1;        // signed sum width
  localparam logic [SW-1:0] HALF = SW'(1) << (FRAC - 1);

  // stage 1: multiply
  logic [PW-1:0]    r_prod;
  logic [DW-1:0]    r_pix1;
  logic [OFS_W-1:0] r_ofs1;
  logic             r_byp1;

  // stage 2: round and offset
  logic [SW-1:0]    r_sum;
  logic [DW-1:0]    r_pix2;
  logic             r_byp2;

  // stage 3: clamp, vde mask
  logic [DW-1:0]    r_data;
  logic             r_sat;

  logic [PW-1:0]    w_prod;
  logic [SW-1:0]    w_rnd;
  logic [SW-1:0]    w_r;
  logic [SW-1:0]    w_ofs_ext;
  logic [SW-1:0]    w_sum;
  logic             w_neg;
  logic             w_over;
  logic [DW-1:0]    w_clamped;

  assign w_prod = PW'(i_pix) * PW'(i_gain);

  // The extra top bit keeps the rounding add from overflowing; after the
  // shift the value is non-negative, so unsigned addition of the
  // sign-extended offset yields the correct two's complement sum.
  assign w_rnd     = {1'b0, r_prod} + HALF;
  assign w_r       = w_rnd >> FRAC;
  assign w_ofs_ext = {{(SW-OFS_W){r_ofs1[OFS_W-1]}}, r_ofs1};
  assign w_sum     = w_r + w_ofs_ext;

  assign w_neg  = r_sum[SW-1];
  assign w_over = ~w_neg & (|r_sum[SW-2:DW]);

  always_comb begin
    w_clamped = r_sum[DW-1:0];
    if (w_neg) begin
      w_clamped = '0;
    end else if (w_over) begin
      w_clamped = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod <= '0;
      r_pix1 <= '0;
      r_ofs1 <= '0;
      r_byp1 <= 1'b0;
    end else begin
      r_prod <= w_prod;
      r_pix1 <= i_pix;
      r_ofs1 <= i_ofs;
      r_byp1 <= i_bypass;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_pix2 <= '0;
      r_byp2 <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_pix2 <= r_pix1;
      r_byp2 <= r_byp1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_sat  <= 1'b0;
    end else if (!i_vde_s3) begin
      r_data <= '0;
      r_sat  <= 1'b0;
    end else if (r_byp2) begin
      r_data <= r_pix2;
      r_sat  <= 1'b0;
    end else begin
      r_data <= w_clamped;
      r_sat  <= w_neg | w_over;
    end
  end

  assign o_data = r_data;
  assign o_sat  = r_sat;

endmodule

// File: rtl/pix_adjust.sv
// ---------------------------------------------------------------------------
// pix_adjust
// Per-channel gain/offset/clamp pixel stage between the video timing source
// and the TMDS encoder. Holds the frame-synchronous configuration registers,
// frame boundary detect, the sync delay line matching the datapath latency,
// and the frame and saturation counters. One pix_chan per colour channel.
// Ports:
//   clk, rst_n     : pixel clock, asynchronous active-low reset
//   data_i         : input pixel, channel k at [k*DW +: DW]
//   vde_i, hsync_i, vsync_i : video enable and syncs (vsync rise = frame)
//   cfg_gain_i     : per-channel unsigned gain, FRAC fractional bits
//   cfg_ofs_i      : per-channel signed offset
//   cfg_bypass_i   : pass pixels unmodified
//   cfg_valid_i    : one-cycle strobe capturing all cfg_* inputs
//   cfg_pending_o  : captured config waiting for the next frame boundary
//   data_o         : processed pixel, LATENCY clocks after data_i
//   vde_o, hsync_o, vsync_o : syncs delayed to match data_o
//   sat_cnt_o      : clamped channel samples in the last completed frame
//   frame_cnt_o    : frame boundaries seen, wraps
// ---------------------------------------------------------------------------
module pix_adjust
  import pix_pkg::*;
#(
  parameter int CH     = 3,
  parameter int DW     = 8,
  parameter int GAIN_W = 9,
  parameter int FRAC   = 7,
  parameter int OFS_W  = DW + 1,
  parameter int SAT_W  = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH*DW-1:0]    data_i,
  input  logic                vde_i,
  input  logic                hsync_i,
  input  logic                vsync_i,
  input  logic [CH*GAIN_W-1:0] cfg_gain_i,
  input  logic [CH*OFS_W-1:0] cfg_ofs_i,
  input  logic                cfg_bypass_i,
  input  logic                cfg_valid_i,
  output logic                cfg_pending_o,
  output logic [CH*DW-1:0]    data_o,
  output logic                vde_o,
  output logic                hsync_o,
  output logic                vsync_o,
  output logic [SAT_W-1:0]    sat_cnt_o,
  output logic [15:0]         frame_cnt_o
);

  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(unity_gain(FRAC));

  // configuration
  logic [CH*GAIN_W-1:0] r_pend_gain;
  logic [CH*OFS_W-1:0]  r_pend_ofs;
  logic                 r_pend_byp;
  logic                 r_pending;
  logic [CH*GAIN_W-1:0] r_act_gain;
  logic [CH*OFS_W-1:0]  r_act_ofs;
  logic                 r_act_byp;

  logic                 r_vs_prev;
  logic                 w_bound;
  logic [15:0]          r_frame_cnt;

  // sync delay line, index i holds the syncs after i+1 clocks
  sync_t                r_sync [LATENCY];
  sync_t                w_sync_in;

  // saturation statistics
  logic [CH-1:0]        w_sat;
  logic [SAT_W-1:0]     r_sat_acc;
  logic [SAT_W-1:0]     r_sat_cnt;
  logic                 r_vso_prev;
  logic                 w_vs_out;
  logic [SAT_W:0]       w_sat_sum;
  logic [SAT_W-1:0]     w_sat_next;

  assign w_bound = vsync_i & ~r_vs_prev;

  // A strobe coinciding with the boundary is routed straight to the active
  // set; the pending set is loaded too so the two never disagree afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_prev   <= 1'b0;
      r_pend_gain <= {CH{UNITY}};
      r_pend_ofs  <= '0;
      r_pend_byp  <= 1'b0;
      r_pending   <= 1'b0;
      r_act_gain  <= {CH{UNITY}};
      r_act_ofs   <= '0;
      r_act_byp   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_vs_prev <= vsync_i;
      if (cfg_valid_i) begin
        r_pend_gain <= cfg_gain_i;
        r_pend_ofs  <= cfg_ofs_i;
        r_pend_byp  <= cfg_bypass_i;
      end
      if (w_bound) begin
        r_act_gain  <= cfg_valid_i ? cfg_gain_i   : r_pend_gain;
        r_act_ofs   <= cfg_valid_i ? cfg_ofs_i    : r_pend_ofs;
        r_act_byp   <= cfg_valid_i ? cfg_bypass_i : r_pend_byp;
        r_pending   <= 1'b0;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end else if (cfg_valid_i) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    w_sync_in       = '0;
    w_sync_in.vde   = vde_i;
    w_sync_in.hsync = hsync_i;
    w_sync_in.vsync = vsync_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= w_sync_in;
      for (int i = 1; i < LATENCY; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  // The channel's output register loads together with r_sync[LATENCY-1],
  // so it is fed the vde one stage earlier.
  for (genvar k = 0; k < CH; k++) begin : g_chan
    pix_chan #(
      .DW     (DW),
      .GAIN_W (GAIN_W),
      .FRAC   (FRAC),
      .OFS_W  (OFS_W)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_pix    (data_i[ch_lo(k, DW) +: DW]),
      .i_gain   (r_act_gain[ch_lo(k, GAIN_W) +: GAIN_W]),
      .i_ofs    (r_act_ofs[ch_lo(k, OFS_W) +: OFS_W]),
      .i_bypass (r_act_byp),
      .i_vde_s3 (r_sync[LATENCY-2].vde),
      .o_data   (data_o[ch_lo(k, DW) +: DW]),
      .o_sat    (w_sat[k])
    );
  end

  // Flags are already masked by the output-stage vde inside each channel.
  always_comb begin
    w_sat_sum = {1'b0, r_sat_acc};
    for (int k = 0; k < CH; k++) begin
      w_sat_sum = w_sat_sum + (SAT_W+1)'(w_sat[k]);
    end
    w_sat_next = w_sat_sum[SAT_W] ? '1 : w_sat_sum[SAT_W-1:0];
  end

  assign w_vs_out = r_sync[LATENCY-1].vsync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_acc  <= '0;
      r_sat_cnt  <= '0;
      r_vso_prev <= 1'b0;
    end else begin
      r_vso_prev <= w_vs_out;
      if (w_vs_out & ~r_vso_prev) begin
        r_sat_cnt <= w_sat_next;
        r_sat_acc <= '0;
      end else begin
        r_sat_acc <= w_sat_next;
      end
    end
  end

  assign cfg_pending_o = r_pending;
  assign vde_o         = r_sync[LATENCY-1].vde;
  assign hsync_o       = r_sync[LATENCY-1].hsync;
  assign vsync_o       = r_sync[LATENCY-1].vsync;
  assign sat_cnt_o     = r_sat_cnt;
  assign frame_cnt_o   = r_frame_cnt;

endmodule

// File: tb/tb_pix_adjust.sv
`timescale 1ns/1ps
module tb_pix_adjust;

  localparam int CH = 3, DW = 8, GAIN_W = 9, FRAC = 7, OFS_W = 9, SAT_W = 24;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [CH*DW-1:0]     data_i;
  logic                 vde_i, hsync_i, vsync_i;
  logic [CH*GAIN_W-1:0] cfg_gain_i;
  logic [CH*OFS_W-1:0]  cfg_ofs_i;
  logic                 cfg_bypass_i, cfg_valid_i;
  logic                 cfg_pending_o;
  logic [CH*DW-1:0]     data_o;
  logic                 vde_o, hsync_o, vsync_o;
  logic [SAT_W-1:0]     sat_cnt_o;
  logic [15:0]          frame_cnt_o;

  always #5 clk = ~clk;

  pix_adjust #(
    .CH(CH), .DW(DW), .GAIN_W(GAIN_W), .FRAC(FRAC), .OFS_W(OFS_W), .SAT_W(SAT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .vde_i(vde_i), .hsync_i(hsync_i),
    .vsync_i(vsync_i), .cfg_gain_i(cfg_gain_i), .cfg_ofs_i(cfg_ofs_i),
    .cfg_bypass_i(cfg_bypass_i), .cfg_valid_i(cfg_valid_i),
    .cfg_pending_o(cfg_pending_o), .data_o(data_o), .vde_o(vde_o),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .sat_cnt_o(sat_cnt_o),
    .frame_cnt_o(frame_cnt_o)
  );

  int errors = 0;
  int checks = 0;

  // expected output-stage view of one input pixel
  typedef struct packed {
    logic [23:0] data;
    logic        vde;
    logic        hs;
    logic        vs;
    logic [3:0]  nsat;
  } exp_t;

  exp_t q[$];
  exp_t vis;

  int act_gain[3], act_ofs[3];  bit act_byp;
  int pend_gain[3], pend_ofs[3]; bit pend_byp; bit pend_flag;
  int s_gain[3], s_ofs[3];       bit s_byp;
  bit vs_prev, ovs_prev;
  int frame_cnt, sat_acc, sat_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void chan_model(input int pix, input int gain, input int ofs,
                                     output int o, output bit sat);
    int r, s;
    r   = (pix * gain + (1 << (FRAC - 1))) >> FRAC;
    s   = r + ofs;
    sat = (s < 0) || (s > 255);
    o   = (s < 0) ? 0 : ((s > 255) ? 255 : s);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      act_gain[k] = 1 << FRAC; act_ofs[k] = 0;
      pend_gain[k] = 1 << FRAC; pend_ofs[k] = 0;
    end
    act_byp = 0; pend_byp = 0; pend_flag = 0;
    vs_prev = 0; ovs_prev = 0;
    frame_cnt = 0; sat_acc = 0; sat_cnt = 0;
    q.delete();
    q.push_back('0);
    q.push_back('0);
    vis = '0;
  endtask

  // one clock: predict the current input pixel, advance, compare outputs
  task automatic tick();
    exp_t e;
    bit   bound, st;
    int   o, tot, new_sat;
    bound  = vsync_i && !vs_prev;
    e      = '0;
    e.vde  = vde_i; e.hs = hsync_i; e.vs = vsync_i;
    if (vde_i) begin
      for (int k = 0; k < 3; k++) begin
        if (act_byp) begin
          e.data[k*8 +: 8] = data_i[k*8 +: 8];
        end else begin
          chan_model(int'(data_i[k*8 +: 8]), act_gain[k], act_ofs[k], o, st);
          e.data[k*8 +: 8] = 8'(o);
          e.nsat = e.nsat + 4'(st);
        end
      end
    end
    if (cfg_valid_i) begin
      pend_gain = s_gain; pend_ofs = s_ofs; pend_byp = s_byp;
    end
    if (bound) begin
      act_gain = pend_gain; act_ofs = pend_ofs; act_byp = pend_byp;
      pend_flag = 0;
      frame_cnt = (frame_cnt + 1) & 16'hFFFF;
    end else if (cfg_valid_i) begin
      pend_flag = 1;
    end
    vs_prev = vsync_i;
    // statistics seen by the output stage this cycle
    tot     = sat_acc + int'(vis.nsat);
    new_sat = sat_cnt;
    if (vis.vs && !ovs_prev) begin
      new_sat = tot; sat_acc = 0;
    end else begin
      sat_acc = tot;
    end
    ovs_prev = vis.vs;
    q.push_back(e);

    @(posedge clk); #1;
    cfg_valid_i = 1'b0;
    sat_cnt = new_sat;
    vis = q.pop_front();
    chk("data",    32'(data_o),        32'(vis.data));
    chk("vde",     32'(vde_o),         32'(vis.vde));
    chk("hsync",   32'(hsync_o),       32'(vis.hs));
    chk("vsync",   32'(vsync_o),       32'(vis.vs));
    chk("pending", 32'(cfg_pending_o), 32'(pend_flag));
    chk("frame",   32'(frame_cnt_o),   32'(frame_cnt));
    chk("satcnt",  32'(sat_cnt_o),     32'(sat_cnt));
  endtask

  task automatic px(input logic [23:0] d, input logic v, input logic h, input logic s);
    data_i = d; vde_i = v; hsync_i = h; vsync_i = s;
    tick();
  endtask

  task automatic strobe(input int g, input int o, input bit b);
    for (int k = 0; k < 3; k++) begin
      s_gain[k] = g; s_ofs[k] = o;
      cfg_gain_i[k*9 +: 9] = 9'(g);
      cfg_ofs_i[k*9 +: 9]  = 9'(o);
    end
    s_byp = b; cfg_bypass_i = b; cfg_valid_i = 1'b1;
  endtask

  task automatic strobe_rand();
    for (int k = 0; k < 3; k++) begin
      s_gain[k] = int'($urandom_range(0, 511));
      s_ofs[k]  = int'($urandom_range(0, 511)) - 256;
      cfg_gain_i[k*9 +: 9] = 9'(s_gain[k]);
      cfg_ofs_i[k*9 +: 9]  = 9'(s_ofs[k]);
    end
    s_byp = ($urandom_range(0, 3) == 0);
    cfg_bypass_i = s_byp; cfg_valid_i = 1'b1;
  endtask

  task automatic vsync_pulse();
    px(24'($urandom), 0, 0, 1);
    px(24'($urandom), 0, 0, 1);
    repeat (4) px(24'($urandom), 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_data",    32'(data_o),        32'h0);
    chk("rst_vde",     32'(vde_o),         32'h0);
    chk("rst_hsync",   32'(hsync_o),       32'h0);
    chk("rst_vsync",   32'(vsync_o),       32'h0);
    chk("rst_pending", 32'(cfg_pending_o), 32'h0);
    chk("rst_sat",     32'(sat_cnt_o),     32'h0);
    chk("rst_frame",   32'(frame_cnt_o),   32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    data_i = '0; vde_i = 0; hsync_i = 0; vsync_i = 0;
    cfg_gain_i = '0; cfg_ofs_i = '0; cfg_bypass_i = 0; cfg_valid_i = 0;
    for (int k = 0; k < 3; k++) begin s_gain[k] = 128; s_ofs[k] = 0; end
    s_byp = 0;
    do_reset();

    // unity pass-through and latency
    vsync_pulse();
    chk("frame_first", 32'(frame_cnt_o), 32'd1);
    px(24'h123456, 1, 0, 0);
    px(24'h000000, 1, 1, 0);
    px(24'h000000, 1, 0, 0);
    chk("lat_123456", 32'(data_o), 32'h123456);
    repeat (20) px(24'($urandom), 1'($urandom), 1'($urandom), 0);

    // gain 2.0 waits for the frame boundary
    strobe(256, 0, 0);
    px(24'h404040, 1, 0, 0);
    chk("pend_set", 32'(cfg_pending_o), 32'd1);
    px(24'h000000, 0, 0, 0);
    px(24'h000000, 0, 0, 0);
    chk("old_cfg", 32'(data_o), 32'h404040);
    vsync_pulse();
    chk("pend_clr", 32'(cfg_pending_o), 32'd0);
    chk("sat_zero", 32'(sat_cnt_o), 32'd0);
    px(24'h404040, 1, 0, 0);
    px(24'h808080, 1, 0, 0);
    px(24'h808080, 1, 0, 0);
    chk("gain2_40", 32'(data_o), 32'h808080);
    px(24'h808080, 1, 0, 0);
    chk("gain2_80", 32'(data_o), 32'hFFFFFF);
    repeat (7) px(24'h808080, 1, 0, 0);
    vsync_pulse();
    chk("sat_30", 32'(sat_cnt_o), 32'd30);

    // random configurations across several frames
    for (int f = 0; f < 5; f++) begin
      strobe_rand();
      for (int i = 0; i < 30; i++) begin
        if (i == 12 && f[0]) strobe_rand();
        px(24'($urandom), ($urandom_range(0, 4) != 0), 1'($urandom), 0);
      end
      vsync_pulse();
    end

    // negative offset
    strobe(128, -16, 0);
    vsync_pulse();
    px(24'h080808, 1, 0, 0);
    px(24'h202020, 1, 0, 0);
    px(24'h000000, 0, 0, 0);
    chk("ofs_08", 32'(data_o), 32'h000000);
    px(24'h000000, 0, 0, 0);
    chk("ofs_20", 32'(data_o), 32'h101010);
    vsync_pulse();
    chk("sat_ofs", 32'(sat_cnt_o), 32'd3);

    // rounding with gain 1.5
    strobe(192, 0, 0);
    vsync_pulse();
    px(24'h030303, 1, 0, 0);
    px(24'h010101, 1, 0, 0);
    px(24'h000000, 0, 0, 0);
    chk("rnd_03", 32'(data_o), 32'h050505);
    px(24'h000000, 0, 0, 0);
    chk("rnd_01", 32'(data_o), 32'h020202);

    // strobe coincident with the boundary, bypass
    strobe(256, 5, 1);
    px(24'h000000, 0, 0, 1);
    chk("coinc_pend", 32'(cfg_pending_o), 32'd0);
    px(24'h000000, 0, 0, 1);
    repeat (4) px(24'h000000, 0, 0, 0);
    px(24'hFFFF00, 1, 0, 0);
    px(24'h123456, 1, 0, 0);
    px(24'h000000, 0, 0, 0);
    chk("byp_ff", 32'(data_o), 32'hFFFF00);
    px(24'h000000, 0, 0, 0);
    chk("byp_12", 32'(data_o), 32'h123456);
    vsync_pulse();
    chk("byp_sat", 32'(sat_cnt_o), 32'd0);

    // asynchronous reset mid-frame with gain 2.0 active
    strobe(256, 0, 0);
    vsync_pulse();
    px(24'h404040, 1, 0, 0);
    px(24'h404040, 1, 0, 0);
    px(24'h404040, 1, 0, 0);
    chk("pre_rst", 32'(data_o), 32'h808080);
    do_reset();
    px(24'h405060, 1, 0, 0);
    px(24'h000000, 0, 0, 0);
    px(24'h000000, 0, 0, 0);
    chk("post_rst", 32'(data_o), 32'h405060);
    chk("post_rst_frame", 32'(frame_cnt_o), 32'd0);
    vsync_pulse();
    chk("post_rst_frame1", 32'(frame_cnt_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
